// File: rtl/des_round_key_gen.sv
// Sequential DES/3DES key schedule: PC-1 on the selected key, then one PC-2
// round key per accepted beat (K1..K16 for encrypt, K16..K1 for decrypt).
module des_round_key_gen #(
    parameter int unsigned NUM_KEYS    = 3,
    parameter logic [15:0] SHIFT_SCHED = 16'h8103
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic [1:0]               key_sel,
    input  logic [64*NUM_KEYS-1:0]   key_in,
    output logic [47:0]              rk,
    output logic [3:0]               rk_round,
    output logic                     rk_valid,
    input  logic                     rk_ready,
    output logic                     rk_last,
    output logic                     busy,
    output logic                     done,
    output logic                     sel_err
);

    localparam int unsigned KEY_W   = 64;
    localparam int unsigned HALF_W  = 28;
    localparam int unsigned CD_W    = 56;
    localparam int unsigned RK_W    = 48;
    localparam int unsigned KEYIN_W = KEY_W * NUM_KEYS;

    // DES tables, 1-based bit positions with bit 1 = MSB
    localparam int unsigned PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int unsigned PC2_TAB [RK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    if ($countones(SHIFT_SCHED) != 4) begin : g_sched_chk
        $error("des_round_key_gen: SHIFT_SCHED must have exactly 4 bits set");
    end
    if (NUM_KEYS < 1 || NUM_KEYS > 4) begin : g_num_chk
        $error("des_round_key_gen: NUM_KEYS must be 1..4");
    end

    typedef enum logic {
        S_IDLE,
        S_GEN
    } state_t;

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] o;
        o = '0;
        for (int i = 0; i < int'(CD_W); i++) begin
            o[6'(CD_W - 1 - i)] = k[6'(KEY_W - PC1_TAB[i])];
        end
        return o;
    endfunction

    function automatic logic [RK_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [RK_W-1:0] o;
        o = '0;
        for (int i = 0; i < int'(RK_W); i++) begin
            o[6'(RK_W - 1 - i)] = cd[6'(CD_W - PC2_TAB[i])];
        end
        return o;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic one);
        return one ? {x[HALF_W-2:0], x[HALF_W-1]} : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic one);
        return one ? {x[0], x[HALF_W-1:1]} : {x[1:0], x[HALF_W-1:2]};
    endfunction

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [HALF_W-1:0]  c_q, c_d, d_q, d_d;
    logic [3:0]         beat_q, beat_d;
    logic               done_q, done_d;
    logic               sel_err_q, sel_err_d;

    logic [KEY_W-1:0]   key_arr [4];
    logic [KEY_W-1:0]   sel_key;
    logic [CD_W-1:0]    cd0;
    logic               sel_valid;

    // Key k sits MSB-first at slot k counted from the top of key_in
    for (genvar g = 0; g < 4; g++) begin : g_key
        if (g < NUM_KEYS) begin : g_used
            assign key_arr[g] = key_in[KEYIN_W-1-g*KEY_W -: KEY_W];
        end else begin : g_pad
            assign key_arr[g] = '0;
        end
    end

    assign sel_key   = key_arr[key_sel];
    assign sel_valid = 32'(key_sel) < NUM_KEYS;
    assign cd0       = pc1(sel_key);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            c_q       <= '0;
            d_q       <= '0;
            beat_q    <= '0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            c_q       <= c_d;
            d_q       <= d_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Decrypt starts from the unrotated halves (total rotation 28 = K16)
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        c_d       = c_q;
        d_d       = d_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        sel_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (sel_valid) begin
                        state_d = S_GEN;
                        mode_d  = mode;
                        beat_d  = '0;
                        if (mode) begin
                            c_d = cd0[CD_W-1:HALF_W];
                            d_d = cd0[HALF_W-1:0];
                        end else begin
                            c_d = rotl(cd0[CD_W-1:HALF_W], SHIFT_SCHED[0]);
                            d_d = rotl(cd0[HALF_W-1:0], SHIFT_SCHED[0]);
                        end
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            S_GEN: begin
                if (rk_ready) begin
                    if (beat_q == 4'd15) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + 4'd1;
                        if (mode_q) begin
                            c_d = rotr(c_q, SHIFT_SCHED[4'd15 - beat_q]);
                            d_d = rotr(d_q, SHIFT_SCHED[4'd15 - beat_q]);
                        end else begin
                            c_d = rotl(c_q, SHIFT_SCHED[beat_q + 4'd1]);
                            d_d = rotl(d_q, SHIFT_SCHED[beat_q + 4'd1]);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rk       = pc2({c_q, d_q});
    assign rk_valid = (state_q == S_GEN);
    assign busy     = (state_q == S_GEN);
    assign rk_round = mode_q ? (4'd15 - beat_q) : beat_q;
    assign rk_last  = rk_valid && (beat_q == 4'd15);
    assign done     = done_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_des_round_key_gen.sv
// Scoreboard bench for des_round_key_gen against an independent DES key schedule model.
module tb_des_round_key_gen;

    localparam logic [63:0] KA = 64'h133457799BBCDFF1;
    localparam logic [63:0] KB = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KC = 64'hAABB09182736CCDD;
    localparam logic [63:0] KD = 64'h0123456789ABCDEF;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct packed {
        logic [47:0] rk;
        logic [3:0]  rd;
        logic        last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [1:0]   key_sel;
    logic [191:0] key_in;
    logic [47:0]  rk;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;
    logic         done;
    logic         sel_err;

    int           n_checks = 0;
    int           n_errors = 0;
    exp_t         sb[$];
    logic [47:0]  mk [16];
    logic         rand_en = 1'b0;

    logic         hold_v = 1'b0;
    logic [47:0]  hold_rk;
    logic [3:0]   hold_rd;
    logic         pend_done = 1'b0;

    des_round_key_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .key_sel  (key_sel),
        .key_in   (key_in),
        .rk       (rk),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_last  (rk_last),
        .busy     (busy),
        .done     (done),
        .sel_err  (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference schedule: cumulative shift count applied to the PC-1 halves
    task automatic build_ks(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        int          tot;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SH[r];
            c = cd[55:28];
            d = cd[27:0];
            for (int s = 0; s < tot; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            for (int j = 0; j < 48; j++) mk[r][47-j] = {c, d}[56-PC2[j]];
        end
    endtask

    function automatic logic [63:0] key_of(input logic [1:0] sel);
        return key_in[191 - 64*int'(sel) -: 64];
    endfunction

    task automatic push_seq(input logic [63:0] key, input logic m);
        exp_t e;
        int   idx;
        build_ks(key);
        for (int b = 0; b < 16; b++) begin
            idx    = m ? 15 - b : b;
            e.rk   = mk[idx];
            e.rd   = 4'(idx);
            e.last = (b == 15);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [1:0] sel, input logic m);
        key_sel = sel;
        mode    = m;
        start   = 1'b1;
        push_seq(key_of(sel), m);
        step();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Ready source: always 1 or a coin flip each cycle
    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rk_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pops on accept, stall freeze, done timing
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_v    = 1'b0;
            pend_done = 1'b0;
        end else begin
            check_eq("done", 64'(done), 64'(pend_done));
            pend_done = 1'b0;
            if (hold_v) begin
                check_eq("stall_rk", 64'(rk), 64'(hold_rk));
                check_eq("stall_round", 64'(rk_round), 64'(hold_rd));
                check_eq("stall_valid", 64'(rk_valid), 64'd1);
            end
            hold_v  = rk_valid && !rk_ready;
            hold_rk = rk;
            hold_rd = rk_round;
            if (rk_valid && rk_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_extra_beat", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check_eq("rk", 64'(rk), 64'(e.rk));
                    check_eq("rk_round", 64'(rk_round), 64'(e.rd));
                    check_eq("rk_last", 64'(rk_last), 64'(e.last));
                    if (e.last) pend_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rk"}, 64'(rk), 64'd0);
        check_eq({tag, "_round"}, 64'(rk_round), 64'd0);
        check_eq({tag, "_valid"}, 64'(rk_valid), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_sel_err"}, 64'(sel_err), 64'd0);
        check_eq({tag, "_last"}, 64'(rk_last), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        key_sel = 2'd0;
        key_in  = {KA, KB, KC};
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Known-answer encrypt with directed spot checks
        start_seq(2'd0, 1'b0);
        check_eq("enc_k1", 64'(rk), 64'h1B02EFFC7072);
        check_eq("enc_k1_round", 64'(rk_round), 64'd0);
        check_eq("enc_k1_valid", 64'(rk_valid), 64'd1);
        step();
        check_eq("enc_k2", 64'(rk), 64'h79AED9DBC9E5);
        repeat (14) step();
        check_eq("enc_k16", 64'(rk), 64'hCB3D8B0E17F5);
        check_eq("enc_k16_last", 64'(rk_last), 64'd1);
        check_eq("enc_k16_round", 64'(rk_round), 64'd15);
        step();
        check_eq("enc_done", 64'(done), 64'd1);
        check_eq("enc_end_valid", 64'(rk_valid), 64'd0);
        check_eq("enc_end_busy", 64'(busy), 64'd0);
        step();

        // Known-answer decrypt
        start_seq(2'd0, 1'b1);
        check_eq("dec_first", 64'(rk), 64'hCB3D8B0E17F5);
        check_eq("dec_first_round", 64'(rk_round), 64'd15);
        repeat (15) step();
        check_eq("dec_last", 64'(rk), 64'h1B02EFFC7072);
        check_eq("dec_last_round", 64'(rk_round), 64'd0);
        check_eq("dec_last_flag", 64'(rk_last), 64'd1);
        step();
        check_eq("dec_done", 64'(done), 64'd1);
        wait_idle("dec");

        // 3DES key selection
        for (int s = 0; s < 3; s++) begin
            step();
            start_seq(2'(s), 1'(s % 2));
            wait_idle("tdes");
        end

        step();
        key_sel = 2'd3;
        start   = 1'b1;
        step();
        start   = 1'b0;
        check_eq("selerr_pulse", 64'(sel_err), 64'd1);
        check_eq("selerr_busy", 64'(busy), 64'd0);
        check_eq("selerr_valid", 64'(rk_valid), 64'd0);
        step();
        check_eq("selerr_clear", 64'(sel_err), 64'd0);
        check_eq("selerr_busy2", 64'(busy), 64'd0);

        // Random back-pressure
        rand_en = 1'b1;
        start_seq(2'd2, 1'b1);
        wait_idle("stall_dec");
        step();
        start_seq(2'd1, 1'b0);
        wait_idle("stall_enc");
        step();
        start_seq(2'd0, 1'b0);
        wait_idle("stall_enc2");
        rand_en = 1'b0;
        step();
        step();

        // Async reset at beat 7
        start_seq(2'd0, 1'b0);
        repeat (7) step();
        check_eq("pre_rst_round", 64'(rk_round), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        start_seq(2'd1, 1'b0);
        wait_idle("post_rst");

        // start during GEN with different mode/key_sel/key_in is ignored
        step();
        start_seq(2'd0, 1'b0);
        repeat (3) step();
        key_in  = {KD, KC, KB};
        key_sel = 2'd2;
        mode    = 1'b1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        wait_idle("ignore");

        // start held across done: second run begins one cycle after done
        step();
        key_in = {KA, KB, KC};
        start_seq(2'd0, 1'b0);
        start   = 1'b1;
        key_in  = {KD, KC, KB};
        key_sel = 2'd1;
        mode    = 1'b1;
        push_seq(KC, 1'b1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            check_eq("b2b_done_seen", 64'(seen), 64'd1);
        end
        check_eq("b2b_gap_valid", 64'(rk_valid), 64'd0);
        step();
        start = 1'b0;
        check_eq("b2b_valid", 64'(rk_valid), 64'd1);
        check_eq("b2b_round", 64'(rk_round), 64'd15);
        wait_idle("b2b");

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
